// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL memory responder: accepts one A-channel request at a time, services it
// against an internal 32-bit word RAM and returns a single D-channel beat after a
// programmable latency. Supports denied/corrupt responses and forced error injection.
module tl_ul_mem_responder #(
   parameter int unsigned       ADDR_W  = 31,
   parameter int unsigned       SRC_W   = 1,
   parameter logic [ADDR_W-1:0] BASE    = '0,
   parameter int unsigned       DEPTH   = 1024,
   parameter int unsigned       LATENCY = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [2:0]        a_opcode,
   input  logic [2:0]        a_param,
   input  logic [2:0]        a_size,
   input  logic [SRC_W-1:0]  a_source,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [3:0]        a_mask,
   input  logic [31:0]       a_data,
   output logic              d_valid,
   input  logic              d_ready,
   output logic [2:0]        d_opcode,
   output logic [1:0]        d_param,
   output logic [2:0]        d_size,
   output logic [SRC_W-1:0]  d_source,
   output logic              d_sink,
   output logic              d_denied,
   output logic [31:0]       d_data,
   output logic              d_corrupt,
   input  logic              err_inject
);

   localparam int unsigned       IDX_W    = $clog2(DEPTH);
   localparam int unsigned       CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [ADDR_W:0]   SPAN     = (ADDR_W + 1)'(4 * DEPTH);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LATENCY - 1);

   localparam logic [2:0] A_PUT_FULL    = 3'd0;
   localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] A_ARITH       = 3'd2;
   localparam logic [2:0] A_LOGIC       = 3'd3;
   localparam logic [2:0] A_GET         = 3'd4;
   localparam logic [2:0] A_HINT        = 3'd5;

   localparam logic [2:0] D_ACK         = 3'd0;
   localparam logic [2:0] D_ACK_DATA    = 3'd1;
   localparam logic [2:0] D_HINT_ACK    = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   logic [31:0]      mem [DEPTH];

   logic             fire;
   logic [ADDR_W:0]  diff;
   logic             hit;
   logic             legal;
   logic [IDX_W-1:0] idx;
   logic [31:0]      rd_word;
   logic             wr_en;
   logic [2:0]       req_opcode;
   logic             req_denied;
   logic             req_corrupt;
   logic [31:0]      req_data;

   logic             unused_param;

   // Naturally aligned accesses of up to one word are the only legal sizes.
   function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] lsb);
      case (size)
         3'd0:    return 1'b1;
         3'd1:    return ~lsb[0];
         3'd2:    return (lsb == 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   // Byte-lane merge used by PutFull/PutPartial.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
      logic [31:0] w;
      w = old_word;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) w[8*b +: 8] = new_word[8*b +: 8];
      end
      return w;
   endfunction

   // Latency counter advances but never wraps past its terminal value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == LAST_CNT) ? c : c + CNT_W'(1);
   endfunction

   assign unused_param = ^a_param;

   assign a_ready  = (state == ST_IDLE) & reset_n;
   assign fire     = a_valid & a_ready;
   assign d_valid  = (state == ST_RESP);
   assign d_param  = 2'b00;
   assign d_sink   = 1'b0;

   // ---- Stage p0: request decode, address check and RAM read at A fire ----
   // Decode the A request into the response it will produce and the RAM write enable.
   always_comb begin
      diff        = {1'b0, a_address} - {1'b0, BASE};
      hit         = ~diff[ADDR_W] && ({1'b0, diff[ADDR_W-1:0]} < SPAN);
      idx         = diff[IDX_W+1:2];
      legal       = hit && size_aligned(a_size, a_address[1:0]) && !err_inject;
      rd_word     = mem[idx];
      wr_en       = 1'b0;
      req_opcode  = D_ACK;
      req_denied  = 1'b1;
      req_corrupt = 1'b0;
      req_data    = '0;
      case (a_opcode)
         A_PUT_FULL, A_PUT_PARTIAL: begin
            wr_en      = legal;
            req_denied = !legal;
         end
         A_GET: begin
            req_opcode  = D_ACK_DATA;
            req_denied  = !legal;
            req_corrupt = !legal;
            req_data    = legal ? rd_word : '0;
         end
         A_ARITH, A_LOGIC: begin
            req_opcode  = D_ACK_DATA;
            req_corrupt = 1'b1;
         end
         A_HINT: begin
            req_opcode = D_HINT_ACK;
            req_denied = err_inject;
         end
         default: ;
      endcase
   end

   // RAM write port; contents deliberately survive reset.
   always_ff @(posedge clock) begin
      if (fire && wr_en) mem[idx] <= merge_bytes(mem[idx], a_data, a_mask);
   end

   // ---- Stage p1: response held until the D beat is accepted ----
   // Capture the response fields at A fire; they stay frozen through WAIT and RESP.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         d_opcode  <= '0;
         d_size    <= '0;
         d_source  <= '0;
         d_denied  <= 1'b0;
         d_corrupt <= 1'b0;
         d_data    <= '0;
      end else if (fire) begin
         d_opcode  <= req_opcode;
         d_size    <= a_size;
         d_source  <= a_source;
         d_denied  <= req_denied;
         d_corrupt <= req_corrupt;
         d_data    <= req_data;
      end
   end

   // FSM state and latency counter registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic: IDLE -> WAIT (skipped for single-cycle latency) -> RESP -> IDLE.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (fire) begin
               if (LATENCY == 1) begin
                  state_nxt = ST_RESP;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = CNT_W'(1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt == LAST_CNT) begin
               state_nxt = ST_RESP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = sat_inc(cnt);
            end
         end
         ST_RESP: begin
            if (d_ready) state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Directed bench for tl_ul_mem_responder: one instance with LATENCY=1 and one with LATENCY=4.
module tb_tl_ul_mem_responder;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  a_opcode = '0;
   logic [2:0]  a_param = '0;
   logic [2:0]  a_size = '0;
   logic [0:0]  a_source = '0;
   logic [30:0] a_address = '0;
   logic [3:0]  a_mask = '0;
   logic [31:0] a_data = '0;
   logic        err_inject = 1'b0;

   logic        a_valid1 = 1'b0, d_ready1 = 1'b0;
   logic        a_ready1, d_valid1, d_sink1, d_denied1, d_corrupt1;
   logic [2:0]  d_opcode1, d_size1;
   logic [1:0]  d_param1;
   logic [0:0]  d_source1;
   logic [31:0] d_data1;

   logic        a_valid4 = 1'b0, d_ready4 = 1'b0;
   logic        a_ready4, d_valid4, d_sink4, d_denied4, d_corrupt4;
   logic [2:0]  d_opcode4, d_size4;
   logic [1:0]  d_param4;
   logic [0:0]  d_source4;
   logic [31:0] d_data4;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   tl_ul_mem_responder #(.LATENCY(1)) u1 (
      .clock(clock), .reset_n(reset_n),
      .a_valid(a_valid1), .a_ready(a_ready1), .a_opcode(a_opcode), .a_param(a_param),
      .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
      .a_data(a_data), .d_valid(d_valid1), .d_ready(d_ready1), .d_opcode(d_opcode1),
      .d_param(d_param1), .d_size(d_size1), .d_source(d_source1), .d_sink(d_sink1),
      .d_denied(d_denied1), .d_data(d_data1), .d_corrupt(d_corrupt1), .err_inject(err_inject)
   );

   tl_ul_mem_responder #(.LATENCY(4)) u4 (
      .clock(clock), .reset_n(reset_n),
      .a_valid(a_valid4), .a_ready(a_ready4), .a_opcode(a_opcode), .a_param(a_param),
      .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
      .a_data(a_data), .d_valid(d_valid4), .d_ready(d_ready4), .d_opcode(d_opcode4),
      .d_param(d_param4), .d_size(d_size4), .d_source(d_source4), .d_sink(d_sink4),
      .d_denied(d_denied4), .d_data(d_data4), .d_corrupt(d_corrupt4), .err_inject(err_inject)
   );

   // One full transaction on the selected instance; returns the D beat and its latency.
   task automatic tx(input bit sel, input logic [2:0] op, input logic [30:0] addr,
                     input logic [2:0] size, input logic [3:0] mask, input logic [31:0] data,
                     input logic inj, input logic src,
                     output logic [2:0] r_op, output logic r_den, output logic r_cor,
                     output logic [31:0] r_dat, output logic [2:0] r_size, output logic r_src,
                     output int r_lat);
      int n;
      a_opcode = op; a_address = addr; a_size = size; a_mask = mask; a_data = data;
      err_inject = inj; a_source = src;
      if (sel) a_valid4 = 1'b1; else a_valid1 = 1'b1;
      n = 0;
      while (!(sel ? a_ready4 : a_ready1) && n < 20) begin
         @(posedge clock); #1; n++;
      end
      if (n >= 20) begin
         n_checks++; n_fail++;
         $display("FAIL accept_timeout: a_ready stayed 0 for %0d cycles, required 1", n);
      end
      @(posedge clock); #1;
      a_valid1 = 1'b0; a_valid4 = 1'b0; err_inject = 1'b0;
      r_lat = 1;
      while (!(sel ? d_valid4 : d_valid1) && r_lat < 20) begin
         @(posedge clock); #1; r_lat++;
      end
      if (!(sel ? d_valid4 : d_valid1)) begin
         n_checks++; n_fail++;
         $display("FAIL resp_timeout: d_valid stayed 0 for %0d cycles, required 1", r_lat);
         r_lat = -1;
      end
      r_op   = sel ? d_opcode4  : d_opcode1;
      r_den  = sel ? d_denied4  : d_denied1;
      r_cor  = sel ? d_corrupt4 : d_corrupt1;
      r_dat  = sel ? d_data4    : d_data1;
      r_size = sel ? d_size4    : d_size1;
      r_src  = sel ? d_source4[0] : d_source1[0];
      if (sel) d_ready4 = 1'b1; else d_ready1 = 1'b1;
      @(posedge clock); #1;
      d_ready1 = 1'b0; d_ready4 = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clock);
      #1;
      n_checks++;
      if (a_ready1 !== 1'b0 || d_valid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_handshake: a_ready=%b d_valid=%b, required 0 0", a_ready1, d_valid1);
      end
      n_checks++;
      if ({d_opcode1, d_param1, d_size1, d_source1, d_sink1, d_denied1, d_data1, d_corrupt1} !== 46'h0) begin
         n_fail++;
         $display("FAIL reset_fields: op=%0d den=%b cor=%b data=%h size=%0d, required all 0",
                  d_opcode1, d_denied1, d_corrupt1, d_data1, d_size1);
      end
      n_checks++;
      if (a_ready4 !== 1'b0 || d_valid4 !== 1'b0 || d_data4 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_u4: a_ready=%b d_valid=%b data=%h, required 0 0 0", a_ready4, d_valid4, d_data4);
      end
      reset_n = 1'b1;
      @(posedge clock); #1;
      n_checks++;
      if (a_ready1 !== 1'b1 || d_valid1 !== 1'b0 || a_ready4 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: a_ready1=%b d_valid1=%b a_ready4=%b, required 1 0 1",
                  a_ready1, d_valid1, a_ready4);
      end
   endtask

   task automatic test_put_get();
      logic [2:0] op, sz; logic den, cor, src; logic [31:0] dat; int lat;
      tx(0, 3'd0, 31'h10, 3'd2, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (op !== 3'd0 || den !== 1'b0 || cor !== 1'b0 || dat !== 32'h0 || lat !== 1) begin
         n_fail++;
         $display("FAIL putfull_ack: op=%0d den=%b cor=%b data=%h lat=%0d, required 0 0 0 00000000 1",
                  op, den, cor, dat, lat);
      end
      n_checks++;
      if (sz !== 3'd2 || src !== 1'b1) begin
         n_fail++;
         $display("FAIL putfull_echo: size=%0d source=%b, required 2 1", sz, src);
      end
      tx(0, 3'd4, 31'h10, 3'd2, 4'hF, 32'h0, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (op !== 3'd1 || den !== 1'b0 || cor !== 1'b0 || dat !== 32'hDEADBEEF || lat !== 1 || src !== 1'b0) begin
         n_fail++;
         $display("FAIL get_after_put: op=%0d den=%b cor=%b data=%h lat=%0d src=%b, required 1 0 0 deadbeef 1 0",
                  op, den, cor, dat, lat, src);
      end
   endtask

   task automatic test_partial();
      logic [2:0] op, sz; logic den, cor, src; logic [31:0] dat; int lat;
      tx(0, 3'd1, 31'h10, 3'd2, 4'b0010, 32'h0000AA00, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (op !== 3'd0 || den !== 1'b0) begin
         n_fail++;
         $display("FAIL putpartial_ack: op=%0d den=%b, required 0 0", op, den);
      end
      tx(0, 3'd4, 31'h10, 3'd2, 4'hF, 32'h0, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (dat !== 32'hDEADAAEF || den !== 1'b0) begin
         n_fail++;
         $display("FAIL putpartial_get: data=%h den=%b, required deadaaef 0", dat, den);
      end
   endtask

   task automatic test_illegal();
      logic [2:0] op, sz; logic den, cor, src; logic [31:0] dat; int lat;
      tx(0, 3'd4, 31'h1000, 3'd2, 4'hF, 32'h0, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (op !== 3'd1 || den !== 1'b1 || cor !== 1'b1 || dat !== 32'h0) begin
         n_fail++;
         $display("FAIL get_out_of_range: op=%0d den=%b cor=%b data=%h, required 1 1 1 00000000", op, den, cor, dat);
      end
      tx(0, 3'd4, 31'h10, 3'd3, 4'hF, 32'h0, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (op !== 3'd1 || den !== 1'b1 || cor !== 1'b1 || dat !== 32'h0 || sz !== 3'd3) begin
         n_fail++;
         $display("FAIL get_size3: op=%0d den=%b cor=%b data=%h size=%0d, required 1 1 1 00000000 3",
                  op, den, cor, dat, sz);
      end
      tx(0, 3'd0, 31'h12, 3'd2, 4'hF, 32'h11111111, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (op !== 3'd0 || den !== 1'b1) begin
         n_fail++;
         $display("FAIL put_misaligned: op=%0d den=%b, required 0 1", op, den);
      end
      tx(0, 3'd4, 31'h11, 3'd0, 4'hF, 32'h0, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (dat !== 32'hDEADAAEF || den !== 1'b0 || cor !== 1'b0) begin
         n_fail++;
         $display("FAIL get_byte_unchanged: data=%h den=%b cor=%b, required deadaaef 0 0", dat, den, cor);
      end
      tx(0, 3'd4, 31'h11, 3'd1, 4'hF, 32'h0, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (den !== 1'b1 || cor !== 1'b1 || dat !== 32'h0) begin
         n_fail++;
         $display("FAIL get_half_misaligned: den=%b cor=%b data=%h, required 1 1 00000000", den, cor, dat);
      end
      tx(0, 3'd0, 31'hFFC, 3'd2, 4'hF, 32'h12345678, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      tx(0, 3'd4, 31'hFFC, 3'd2, 4'hF, 32'h0, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (dat !== 32'h12345678 || den !== 1'b0) begin
         n_fail++;
         $display("FAIL get_last_word: data=%h den=%b, required 12345678 0", dat, den);
      end
      tx(0, 3'd0, 31'h0, 3'd2, 4'hF, 32'h13572468, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      tx(0, 3'd0, 31'h1000, 3'd2, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (op !== 3'd0 || den !== 1'b1) begin
         n_fail++;
         $display("FAIL put_out_of_range: op=%0d den=%b, required 0 1", op, den);
      end
      tx(0, 3'd4, 31'h0, 3'd2, 4'hF, 32'h0, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (dat !== 32'h13572468) begin
         n_fail++;
         $display("FAIL no_alias_write: data=%h, required 13572468", dat);
      end
   endtask

   task automatic test_err_inject();
      logic [2:0] op, sz; logic den, cor, src; logic [31:0] dat; int lat;
      tx(0, 3'd0, 31'h20, 3'd2, 4'hF, 32'h01020304, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      tx(0, 3'd0, 31'h20, 3'd2, 4'hF, 32'h55555555, 1'b1, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (op !== 3'd0 || den !== 1'b1) begin
         n_fail++;
         $display("FAIL inject_put: op=%0d den=%b, required 0 1", op, den);
      end
      tx(0, 3'd4, 31'h20, 3'd2, 4'hF, 32'h0, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (dat !== 32'h01020304 || den !== 1'b0) begin
         n_fail++;
         $display("FAIL inject_old_data: data=%h den=%b, required 01020304 0", dat, den);
      end
   endtask

   task automatic test_opcodes();
      logic [2:0] op, sz; logic den, cor, src; logic [31:0] dat; int lat;
      tx(0, 3'd5, 31'h10, 3'd2, 4'hF, 32'h0, 1'b0, 1'b1, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (op !== 3'd2 || den !== 1'b0 || cor !== 1'b0 || dat !== 32'h0) begin
         n_fail++;
         $display("FAIL hint: op=%0d den=%b cor=%b data=%h, required 2 0 0 00000000", op, den, cor, dat);
      end
      tx(0, 3'd5, 31'h10, 3'd2, 4'hF, 32'h0, 1'b1, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (op !== 3'd2 || den !== 1'b1) begin
         n_fail++;
         $display("FAIL hint_inject: op=%0d den=%b, required 2 1", op, den);
      end
      tx(0, 3'd2, 31'h10, 3'd2, 4'hF, 32'h77777777, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (op !== 3'd1 || den !== 1'b1 || cor !== 1'b1 || dat !== 32'h0) begin
         n_fail++;
         $display("FAIL arith: op=%0d den=%b cor=%b data=%h, required 1 1 1 00000000", op, den, cor, dat);
      end
      tx(0, 3'd3, 31'h10, 3'd2, 4'hF, 32'h77777777, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (op !== 3'd1 || den !== 1'b1 || cor !== 1'b1) begin
         n_fail++;
         $display("FAIL logic_op: op=%0d den=%b cor=%b, required 1 1 1", op, den, cor);
      end
      tx(0, 3'd6, 31'h10, 3'd2, 4'hF, 32'h0, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (op !== 3'd0 || den !== 1'b1 || cor !== 1'b0) begin
         n_fail++;
         $display("FAIL opcode6: op=%0d den=%b cor=%b, required 0 1 0", op, den, cor);
      end
      tx(0, 3'd4, 31'h10, 3'd2, 4'hF, 32'h0, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (dat !== 32'hDEADAAEF) begin
         n_fail++;
         $display("FAIL atomic_no_write: data=%h, required deadaaef", dat);
      end
   endtask

   task automatic test_latency_backpressure();
      logic [2:0] op, sz; logic den, cor, src; logic [31:0] dat; int lat;
      tx(1, 3'd0, 31'h40, 3'd2, 4'hF, 32'hA5A5A5A5, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (lat !== 4 || op !== 3'd0 || den !== 1'b0) begin
         n_fail++;
         $display("FAIL lat4_put: lat=%0d op=%0d den=%b, required 4 0 0", lat, op, den);
      end
      a_opcode = 3'd4; a_address = 31'h40; a_size = 3'd2; a_mask = 4'hF; a_source = 1'b1;
      a_valid4 = 1'b1;
      @(posedge clock); #1;
      a_valid4 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) begin
            @(posedge clock); #1;
         end
         n_checks++;
         if (d_valid4 !== (k == 4) || a_ready4 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat4_timing cycle %0d: d_valid=%b a_ready=%b, required %b 0", k, d_valid4, a_ready4, (k == 4));
         end
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clock); #1;
         n_checks++;
         if (d_valid4 !== 1'b1 || d_data4 !== 32'hA5A5A5A5 || d_opcode4 !== 3'd1 ||
             d_source4 !== 1'b1 || d_denied4 !== 1'b0 || a_ready4 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_%0d: d_valid=%b data=%h op=%0d src=%b den=%b a_ready=%b, required 1 a5a5a5a5 1 1 0 0",
                     k, d_valid4, d_data4, d_opcode4, d_source4, d_denied4, a_ready4);
         end
      end
      a_opcode = 3'd5; a_source = 1'b0; a_valid4 = 1'b1; d_ready4 = 1'b1;
      n_checks++;
      if (a_ready4 !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_ready_in_resp: a_ready=%b, required 0", a_ready4);
      end
      @(posedge clock); #1;
      d_ready4 = 1'b0;
      n_checks++;
      if (a_ready4 !== 1'b1 || d_valid4 !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_after_accept: a_ready=%b d_valid=%b, required 1 0", a_ready4, d_valid4);
      end
      @(posedge clock); #1;
      a_valid4 = 1'b0;
      lat = 1;
      while (!d_valid4 && lat < 20) begin
         @(posedge clock); #1; lat++;
      end
      n_checks++;
      if (lat !== 4 || d_opcode4 !== 3'd2 || d_denied4 !== 1'b0 || d_source4 !== 1'b0 || d_data4 !== 32'h0) begin
         n_fail++;
         $display("FAIL b2b_hint: lat=%0d op=%0d den=%b src=%b data=%h, required 4 2 0 0 00000000",
                  lat, d_opcode4, d_denied4, d_source4, d_data4);
      end
      d_ready4 = 1'b1;
      @(posedge clock); #1;
      d_ready4 = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [2:0] op, sz; logic den, cor, src; logic [31:0] dat; int lat;
      a_opcode = 3'd4; a_address = 31'h40; a_size = 3'd2; a_source = 1'b1; a_valid4 = 1'b1;
      @(posedge clock); #1;
      a_valid4 = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b0;
      @(posedge clock); #1;
      n_checks++;
      if (d_valid4 !== 1'b0 || a_ready4 !== 1'b0 || d_data4 !== 32'h0) begin
         n_fail++;
         $display("FAIL midreset_in_reset: d_valid=%b a_ready=%b data=%h, required 0 0 00000000",
                  d_valid4, a_ready4, d_data4);
      end
      reset_n = 1'b1;
      #1;
      n_checks++;
      if (a_ready4 !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_release: a_ready=%b, required 1", a_ready4);
      end
      for (int k = 0; k < 6; k++) begin
         @(posedge clock); #1;
         n_checks++;
         if (d_valid4 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_stale_%0d: d_valid=%b, required 0", k, d_valid4);
         end
      end
      tx(1, 3'd4, 31'h40, 3'd2, 4'hF, 32'h0, 1'b0, 1'b0, op, den, cor, dat, sz, src, lat);
      n_checks++;
      if (lat !== 4 || dat !== 32'hA5A5A5A5 || den !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_after: lat=%0d data=%h den=%b, required 4 a5a5a5a5 0", lat, dat, den);
      end
   endtask

   initial begin
      test_reset();
      test_put_get();
      test_partial();
      test_illegal();
      test_err_inject();
      test_opcodes();
      test_latency_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
